// File: rtl/key_event_ctrl.sv
// Debounced key channels with press/release/long events and optional repeat.
// Define KEY_AUTOREPEAT_EN to build the auto-repeat logic in the LONG state.
module key_event_ctrl #(
  parameter int NUM_KEYS        = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int CNT_W           = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [NUM_KEYS-1:0] key_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_press
);

  typedef enum logic [2:0] {
    IDLE, DB_PRESS, HELD, LONG, DB_REL
  } state_t;

  localparam logic [CNT_W-1:0] DB_END =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_END =
    CNT_W'(LONG_CYCLES - 1);

  localparam logic [NUM_KEYS-1:0] REL_LVL =
    {NUM_KEYS{ACTIVE_LOW}};

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;
  logic [NUM_KEYS-1:0] p;

  // Sync flops idle at the released pin level so reset exit is quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  assign p = s2 ^ REL_LVL;
  assign any_press = |press_pulse;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             was_long;
    logic             lvl;
    logic             prs;
    logic             rel;
    logic             lng;

    assign key_level[k]     = lvl;
    assign press_pulse[k]   = prs;
    assign release_pulse[k] = rel;
    assign long_pulse[k]    = lng;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_END =
      CNT_W'(REPEAT_CYCLES - 1);
    logic rpt;
    assign repeat_pulse[k] = rpt;
`else
    assign repeat_pulse[k] = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st       <= IDLE;
        cnt      <= '0;
        was_long <= 1'b0;
        lvl      <= 1'b0;
        prs      <= 1'b0;
        rel      <= 1'b0;
        lng      <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt      <= 1'b0;
`endif
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        lng <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt <= 1'b0;
`endif
        if (!key_en[k]) begin
          st  <= IDLE;
          cnt <= '0;
          lvl <= 1'b0;
        end else begin
          unique case (st)
            IDLE: begin
              cnt <= '0;
              if (p[k]) st <= DB_PRESS;
            end
            DB_PRESS: begin
              if (!p[k]) begin
                st  <= IDLE;
                cnt <= '0;
              end else if (cnt == DB_END) begin
                st       <= HELD;
                cnt      <= '0;
                was_long <= 1'b0;
                prs      <= 1'b1;
                lvl      <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            HELD: begin
              if (!p[k]) begin
                st  <= DB_REL;
                cnt <= '0;
              end else if (cnt == LONG_END) begin
                st       <= LONG;
                cnt      <= '0;
                was_long <= 1'b1;
                lng      <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            LONG: begin
              if (!p[k]) begin
                st  <= DB_REL;
                cnt <= '0;
              end else begin
`ifdef KEY_AUTOREPEAT_EN
                if (cnt == REP_END) begin
                  cnt <= '0;
                  rpt <= 1'b1;
                end else begin
                  cnt <= cnt + 1'b1;
                end
`else
                cnt <= '0;
`endif
              end
            end
            DB_REL: begin
              // A bounce back to pressed resumes the hold silently.
              if (p[k]) begin
                st  <= was_long ? LONG : HELD;
                cnt <= '0;
              end else if (cnt == DB_END) begin
                st  <= IDLE;
                cnt <= '0;
                rel <= 1'b1;
                lvl <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              st  <= IDLE;
              cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl.
// DEBOUNCE=4, LONG=20, REPEAT=5, four active-low keys.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] key_en;
  logic [3:0] key_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] long_pulse;
  logic [3:0] repeat_pulse;
  logic       any_press;

  int checks = 0;
  int errors = 0;

  key_event_ctrl #(
    .NUM_KEYS(4),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(5),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .key_en(key_en),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    key_in = 4'hF;
    key_en = 4'hF;
    #3;
    checks++;
    if ({key_level, press_pulse, release_pulse,
         long_pulse, repeat_pulse, any_press} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0",
        {key_level, press_pulse, release_pulse,
         long_pulse, repeat_pulse, any_press});
    end
    step(2);
    reset = 1'b1;
    step(10);
    checks++;
    if ({key_level, press_pulse, any_press} !== 9'd0) begin
      errors++;
      $display("FAIL reset_quiet got %h exp 0",
        {key_level, press_pulse, any_press});
    end
  endtask

  task automatic test_press;
    key_in[0] = 1'b0;
    step(6);
    checks++;
    if (press_pulse !== 4'b0000 || key_level !== 4'b0000) begin
      errors++;
      $display("FAIL press_early got p=%b l=%b exp 0 0",
        press_pulse, key_level);
    end
    step(1);
    checks++;
    if (press_pulse !== 4'b0001 || any_press !== 1'b1 ||
        key_level !== 4'b0001) begin
      errors++;
      $display("FAIL press_edge6 got p=%b a=%b l=%b exp 0001 1 0001",
        press_pulse, any_press, key_level);
    end
    step(1);
    checks++;
    if (press_pulse !== 4'b0000 || any_press !== 1'b0 ||
        key_level !== 4'b0001) begin
      errors++;
      $display("FAIL press_after got p=%b a=%b l=%b exp 0000 0 0001",
        press_pulse, any_press, key_level);
    end
    key_in[0] = 1'b1;
    step(6);
    checks++;
    if (release_pulse !== 4'b0000 || key_level !== 4'b0001) begin
      errors++;
      $display("FAIL rel_early got r=%b l=%b exp 0000 0001",
        release_pulse, key_level);
    end
    step(1);
    checks++;
    if (release_pulse !== 4'b0001 || key_level !== 4'b0000) begin
      errors++;
      $display("FAIL rel_edge6 got r=%b l=%b exp 0001 0000",
        release_pulse, key_level);
    end
    step(1);
    checks++;
    if (release_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL rel_after got r=%b exp 0000", release_pulse);
    end
    step(4);
  endtask

  task automatic test_bounce;
    logic [3:0] act;
    act = '0;
    for (int i = 0; i < 20; i++) begin
      key_in[1] = i[0] ? 1'b1 : 1'b0;
      for (int j = 0; j < 2; j++) begin
        step(1);
        act |= press_pulse | release_pulse | long_pulse |
               repeat_pulse | key_level;
      end
    end
    key_in[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step(1);
      act |= press_pulse | release_pulse | long_pulse |
             repeat_pulse | key_level;
    end
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_quiet got %b exp 0000", act);
    end
  endtask

  task automatic test_long;
    int p_n, p_e, l_n, l_e, r_n, r_e, rel_n;
    p_n = 0; p_e = -1; l_n = 0; l_e = -1;
    r_n = 0; r_e = -1; rel_n = 0;
    key_in[2] = 1'b0;
    for (int e = 0; e < 60; e++) begin
      step(1);
      if (press_pulse[2]) begin p_n++; p_e = e; end
      if (long_pulse[2]) begin l_n++; l_e = e; end
      if (repeat_pulse[2]) begin
        if (r_n == 0) r_e = e;
        r_n++;
      end
      if (release_pulse[2]) rel_n++;
    end
    checks++;
    if (p_n !== 1 || p_e !== 6) begin
      errors++;
      $display("FAIL long_press got n=%0d e=%0d exp 1 6", p_n, p_e);
    end
    checks++;
    if (l_n !== 1 || l_e !== 26) begin
      errors++;
      $display("FAIL long_evt got n=%0d e=%0d exp 1 26", l_n, l_e);
    end
`ifdef KEY_AUTOREPEAT_EN
    checks++;
    if (r_n !== 6 || r_e !== 31) begin
      errors++;
      $display("FAIL repeat got n=%0d first=%0d exp 6 31", r_n, r_e);
    end
`else
    checks++;
    if (r_n !== 0) begin
      errors++;
      $display("FAIL repeat got n=%0d exp 0", r_n);
    end
`endif
    key_in[2] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step(1);
      if (release_pulse[2]) rel_n++;
    end
    checks++;
    if (rel_n !== 1 || key_level[2] !== 1'b0) begin
      errors++;
      $display("FAIL long_rel got n=%0d l=%b exp 1 0",
        rel_n, key_level[2]);
    end
    step(4);
  endtask

  task automatic test_glitch;
    int rel_t, rel_n, prs_n;
    logic lvl_ok;
    rel_t = -1; rel_n = 0; prs_n = 0; lvl_ok = 1'b1;
    key_in[0] = 1'b0;
    step(8);
    key_in[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step(1);
      if (release_pulse[0]) rel_n++;
    end
    key_in[0] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      step(1);
      if (release_pulse[0]) rel_n++;
      if (press_pulse[0]) prs_n++;
    end
    key_in[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step(1);
      if (release_pulse[0]) begin rel_n++; rel_t = t; end
      if (press_pulse[0]) prs_n++;
      if (t < 7 && key_level[0] !== 1'b1) lvl_ok = 1'b0;
    end
    checks++;
    if (rel_n !== 1 || rel_t !== 7) begin
      errors++;
      $display("FAIL glitch_rel got n=%0d t=%0d exp 1 7", rel_n, rel_t);
    end
    checks++;
    if (prs_n !== 0 || lvl_ok !== 1'b1) begin
      errors++;
      $display("FAIL glitch_held got prs=%0d lvl_ok=%b exp 0 1",
        prs_n, lvl_ok);
    end
  endtask

  task automatic test_simul;
    int a_n, a_t;
    logic [3:0] pv;
    a_n = 0; a_t = -1; pv = '0;
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      step(1);
      if (any_press) begin
        a_n++; a_t = t; pv = press_pulse;
      end
    end
    checks++;
    if (a_n !== 1 || a_t !== 7 || pv !== 4'b1001) begin
      errors++;
      $display("FAIL simul got n=%0d t=%0d p=%b exp 1 7 1001",
        a_n, a_t, pv);
    end
    key_in = 4'hF;
    step(10);
  endtask

  task automatic test_reset_mid;
    int t_p;
    key_in[1] = 1'b0;
    step(4);
    reset = 1'b0;
    #2;
    checks++;
    if ({key_level, press_pulse, any_press} !== 9'd0) begin
      errors++;
      $display("FAIL rst_dbp got %h exp 0",
        {key_level, press_pulse, any_press});
    end
    step(2);
    reset = 1'b1;
    step(30);
    checks++;
    if (key_level !== 4'b0010) begin
      errors++;
      $display("FAIL pre_rst_long got %b exp 0010", key_level);
    end
    reset = 1'b0;
    #2;
    checks++;
    if ({key_level, press_pulse, release_pulse,
         long_pulse, repeat_pulse, any_press} !== 21'd0) begin
      errors++;
      $display("FAIL rst_long got %h exp 0",
        {key_level, press_pulse, release_pulse,
         long_pulse, repeat_pulse, any_press});
    end
    step(2);
    reset = 1'b1;
    t_p = -1;
    for (int t = 1; t <= 10; t++) begin
      step(1);
      if (press_pulse[1] && t_p < 0) t_p = t;
    end
    checks++;
    if (t_p !== 7) begin
      errors++;
      $display("FAIL rst_repress got t=%0d exp 7", t_p);
    end
  endtask

  task automatic test_enable;
    logic [3:0] act;
    int t_p;
    act = '0;
    key_en[1] = 1'b0;
    step(1);
    checks++;
    if (key_level[1] !== 1'b0) begin
      errors++;
      $display("FAIL en_level got %b exp 0", key_level[1]);
    end
    for (int t = 0; t < 10; t++) begin
      step(1);
      act |= press_pulse | release_pulse | long_pulse |
             repeat_pulse | key_level;
    end
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL en_quiet got %b exp 0000", act);
    end
    key_en[1] = 1'b1;
    t_p = -1;
    for (int t = 1; t <= 8; t++) begin
      step(1);
      if (press_pulse[1] && t_p < 0) t_p = t;
    end
    checks++;
    if (t_p !== 5) begin
      errors++;
      $display("FAIL en_repress got t=%0d exp 5", t_p);
    end
    key_en[1] = 1'b0;
    key_in[1] = 1'b1;
    act = '0;
    for (int t = 0; t < 10; t++) begin
      step(1);
      act |= release_pulse;
    end
    key_en[1] = 1'b1;
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL en_norel got %b exp 0000", act);
    end
    step(4);
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_long();
    test_glitch();
    test_simul();
    test_reset_mid();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
